// File: rtl/uart_rx_frame_deser_if.sv
// Bundle of the deserializer's control, sampler and consumer signals.
//   master : the environment side (drives sampler strobes, enables and ack)
//   slave  : the deserializer side (drives frame data, status and error flags)
interface uart_rx_frame_deser_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  deser_en;
  logic                  sampled_bit;
  logic                  data_sampled;
  logic                  par_en;
  logic                  par_typ;
  logic                  data_ack;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  overrun_err;
  logic                  busy;

  modport master (
    output deser_en, sampled_bit, data_sampled, par_en, par_typ, data_ack,
    input  p_data, data_valid, par_err, stp_err, overrun_err, busy
  );

  modport slave (
    input  deser_en, sampled_bit, data_sampled, par_en, par_typ, data_ack,
    output p_data, data_valid, par_err, stp_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_deser.sv
// UART receive frame deserializer. Consumes one sampled bit per data_sampled
// strobe, assembles start/data/parity/stop, and presents good frames on p_data
// with a data_valid/data_ack handshake.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - slave modport: deser_en, sampled_bit, data_sampled, par_en, par_typ,
//          data_ack in; p_data, data_valid, par_err, stp_err, overrun_err, busy out
module uart_rx_frame_deser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = 0
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_frame_deser_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e                r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [CNT_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [DATA_WIDTH-1:0] r_p_data, w_p_data;
  logic                  r_par_en, w_par_en;
  logic                  r_par_typ, w_par_typ;
  logic                  r_par_bad, w_par_bad;
  logic                  r_data_valid, w_data_valid;
  logic                  r_par_err, w_par_err;
  logic                  r_stp_err, w_stp_err;
  logic                  r_overrun, w_overrun;
  logic                  r_busy, w_busy;

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_shift      = r_shift;
    w_p_data     = r_p_data;
    w_par_en     = r_par_en;
    w_par_typ    = r_par_typ;
    w_par_bad    = r_par_bad;
    w_data_valid = r_data_valid;
    w_par_err    = r_par_err;
    w_stp_err    = r_stp_err;
    w_overrun    = 1'b0;
    w_idx        = (MSB_FIRST != 0) ? CNT_W'(DATA_WIDTH - 1) - r_cnt : r_cnt;

    // Ack clears first; a good frame ending this cycle overrides it below.
    if (bus.data_ack) w_data_valid = 1'b0;

    if (!bus.deser_en) begin
      w_state = StIdle;
    end else if (bus.data_sampled) begin
      unique case (r_state)
        StIdle: begin
          if (!bus.sampled_bit) begin
            w_state   = StData;
            w_cnt     = '0;
            w_par_en  = bus.par_en;
            w_par_typ = bus.par_typ;
            w_par_bad = 1'b0;   // stays 0 when parity is disabled
          end
        end
        StData: begin
          for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (w_idx == CNT_W'(i)) w_shift[i] = bus.sampled_bit;
          end
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_WIDTH - 1)) w_state = r_par_en ? StParity : StStop;
        end
        StParity: begin
          w_par_bad = ((^r_shift) ^ r_par_typ) != bus.sampled_bit;
          w_state   = StStop;
        end
        StStop: begin
          w_state   = StIdle;
          w_stp_err = ~bus.sampled_bit;
          w_par_err = r_par_bad;
          if (bus.sampled_bit && !r_par_bad) begin
            w_p_data     = r_shift;
            w_data_valid = 1'b1;
            w_overrun    = r_data_valid & ~bus.data_ack;
          end
        end
        default: w_state = StIdle;
      endcase
    end

    w_busy = (w_state != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_shift      <= w_shift;
      r_p_data     <= w_p_data;
      r_par_en     <= w_par_en;
      r_par_typ    <= w_par_typ;
      r_par_bad    <= w_par_bad;
      r_data_valid <= w_data_valid;
      r_par_err    <= w_par_err;
      r_stp_err    <= w_stp_err;
      r_overrun    <= w_overrun;
      r_busy       <= w_busy;
    end
  end

  assign bus.p_data      = r_p_data;
  assign bus.data_valid  = r_data_valid;
  assign bus.par_err     = r_par_err;
  assign bus.stp_err     = r_stp_err;
  assign bus.overrun_err = r_overrun;
  assign bus.busy        = r_busy;
endmodule

// File: doc/uart_rx_frame_deser.md
UART_RX_FRAME_DESER -- requirements
Module: uart_rx_frame_deser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 = first data bit maps to p_data[0], 1 = first data bit maps to p_data[DATA_WIDTH-1].
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port deser_en, input, 1, block enable; low forces IDLE.
REQ-006 SHALL have port sampled_bit, input, 1, bit value from the sampler.
REQ-007 SHALL have port data_sampled, input, 1, one-cycle strobe meaning sampled_bit is valid this cycle.
REQ-008 SHALL have port par_en, input, 1, parity bit present.
REQ-009 SHALL have port par_typ, input, 1, 0 = even, 1 = odd.
REQ-010 SHALL have port data_ack, input, 1, consumer has taken p_data.
REQ-011 SHALL have port p_data, output, DATA_WIDTH, last good frame.
REQ-012 SHALL have port data_valid, output, 1, p_data holds unacknowledged data.
REQ-013 SHALL have port par_err, output, 1, parity error of the last completed frame.
REQ-014 SHALL have port stp_err, output, 1, stop error of the last completed frame.
REQ-015 SHALL have port overrun_err, output, 1, one-cycle pulse when a good frame overwrites unacknowledged data.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, DATA, PARITY and STOP; the FSM SHALL advance only on cycles where data_sampled=1.
REQ-018 IDLE: a strobe with sampled_bit=0 is the start bit. On that strobe, go to DATA, clear the bit counter, and latch par_en and par_typ. A strobe with sampled_bit=1 keeps the FSM in IDLE.
REQ-019 DATA: each strobe stores sampled_bit into an internal shift register at the index given by MSB_FIRST and increments the bit counter. After DATA_WIDTH strobes, go to PARITY if latched par_en=1, otherwise go to STOP.
REQ-020 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits wide and SHALL never wrap within a frame.
REQ-021 PARITY: expected bit = XOR of the data bits, inverted when latched par_typ=1. Record the mismatch, then go to STOP.
REQ-022 STOP: the strobe is the frame end. stp_err is set if sampled_bit=0. The FSM returns to IDLE on the same edge.
REQ-023 At frame end, par_err and stp_err SHALL update to this frame's results and hold until the next frame end. par_err SHALL be 0 when parity is disabled.
REQ-024 Good frame (no errors): on the frame-end edge, p_data SHALL load the shift register and data_valid SHALL go to 1; latency is one clk after the stop strobe.
REQ-025 Errored frame: p_data and data_valid SHALL remain unchanged.
REQ-026 data_valid SHALL clear on the cycle after data_ack=1 unless a good frame ends in the same cycle.
REQ-027 Good frame end with data_valid=1 and data_ack=0: p_data SHALL be overwritten, data_valid SHALL stay 1, and overrun_err SHALL pulse for exactly one cycle.
REQ-028 Good frame end in the same cycle as data_ack=1: the new data SHALL load, data_valid SHALL stay 1, and there SHALL be no overrun.
REQ-029 data_ack while data_valid=0 SHALL be ignored.
REQ-030 par_en and par_typ changes mid-frame SHALL NOT affect the current frame.
REQ-031 deser_en=0 SHALL synchronously force IDLE and discard the partial frame; p_data, data_valid and the error flags SHALL hold.
REQ-032 data_sampled=1 while deser_en=0 SHALL be ignored.
REQ-033 busy SHALL be a registered decode of the FSM state, not a combinational function of inputs.

Reset
REQ-034 rst=0 SHALL asynchronously set the FSM to IDLE and clear the bit counter and the shift register.
REQ-035 rst=0 SHALL asynchronously drive p_data=0, data_valid=0, par_err=0, stp_err=0, overrun_err=0 and busy=0.
REQ-036 Reset asserted mid-frame SHALL discard the frame. After release, the block SHALL wait in IDLE for a new start bit, with no spurious data_valid.

Verification
REQ-037 DATA_WIDTH=8, MSB_FIRST=0, par_en=0; bits 0,1,0,1,0,0,1,0,1,1 (start, data LSB-first, stop) -> p_data=0xA5, data_valid=1 one clk after the stop strobe, par_err=0, stp_err=0.
REQ-038 par_en=1, par_typ=0; data 0xA5 with parity bit 1 -> par_err=1, data_valid stays 0, p_data unchanged.
REQ-039 Data 0x3C with stop bit 0 -> stp_err=1, no data_valid; next good frame 0x11 -> stp_err=0, p_data=0x11.
REQ-040 Frames 0x55 then 0xAA with no data_ack -> overrun_err single-cycle pulse, p_data=0xAA. A repeat with data_ack in the frame-end cycle -> no overrun, data_valid=1.
REQ-041 deser_en dropped after 4 data bits, or rst pulsed after 4 data bits -> busy=0 next cycle, no data_valid. A following full frame 0x0F decodes correctly.
REQ-042 MSB_FIRST=1, DATA_WIDTH=7; data bits 1,0,0,0,0,0,1 -> p_data=7'h41. A start strobe with sampled_bit=1 in IDLE -> busy stays 0.
